// File: rtl/key_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_DEB   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_DEB = 2'd3
    } key_state_t;

    // 20 ms and 1 s at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned LONG_CYCLES_DEF     = 50000000;
    localparam int unsigned CNT_W_DEF           = 27;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce/long-press FSM and registered pulses.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic CLK_50M,
    input  logic RST_N,
    input  logic key_n,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_level
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic             meta;
    logic             sync;
    key_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             long_done;

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= key_n;
            sync <= meta;
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            cnt         <= '0;
            long_done   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_level   <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!sync) begin
                        state <= PRESS_DEB;
                        cnt   <= '0;
                    end
                end
                PRESS_DEB: begin
                    if (sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state     <= PRESSED;
                        cnt       <= '0;
                        key_press <= 1'b1;
                        key_level <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (sync) begin
                        state <= RELEASE_DEB;
                        cnt   <= '0;
                    end else begin
                        // hold counter saturates; long_done limits the pulse to once per press
                        if (cnt != LONG_LAST) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                        if (cnt == LONG_LAST && !long_done) begin
                            key_long  <= 1'b1;
                            long_done <= 1'b1;
                        end
                    end
                end
                RELEASE_DEB: begin
                    if (!sync) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        key_release <= 1'b1;
                        key_level   <= 1'b0;
                        long_done   <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Board push-button input stage: KEY_NUM independent debounced key channels.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned KEY_NUM         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic               CLK_50M,
    input  logic               RST_N,
    input  logic [KEY_NUM-1:0] KEY_N,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_level
);

    for (genvar i = 0; i < int'(KEY_NUM); i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .CLK_50M     (CLK_50M),
            .RST_N       (RST_N),
            .key_n       (KEY_N[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i]),
            .key_level   (key_level[i])
        );
    end

endmodule
